cpu: RTL and testbench
======================

// Module: cpu
// PURPOSE
//  Multi-cycle 32-bit ARM-subset processor with internal byte RAM; top of the CPU project.
//  Executes data-processing, LDR/STR word/byte and B/BL, all condition-coded, from an internal RAM.
//  The bench preloads the RAM over the hierarchy; cpu.ram.Mem[] and cpu.IR must keep these names.
// PARAMETERS
//  MEM_BYTES  256  RAM size in bytes; addresses wrap modulo MEM_BYTES
//  RESET_PC   0    PC value after reset
// PORTS
//  clk   in  1  single clock, rising-edge
//  clr   in  1  asynchronous, active-low reset
//  run   in  1  1 = FSM advances; 0 = every register holds its value
//  halt  in  1  1 = stop in FETCH; no new instruction fetched
// BEHAVIOUR
//  Reset, clr=0, async: R0-R14=0, PC(R15)=RESET_PC, NZCV=0, IR=0, state=FETCH. RAM is not reset.
//  States:
//   FETCH  IR<=word(PC); PC<=PC+4; next EXEC.
//   EXEC   Evaluate cond. False: next FETCH, no side effects.
//          DP/B/BL complete in EXEC, so they take 2 cycles; LDR/STR compute the address, next MEM.
//   MEM    LDR/STR access, writeback; next FETCH (3 cycles total).
//  Memory is big-endian: word(A) = {Mem[A],Mem[A+1],Mem[A+2],Mem[A+3]}.
//   Word accesses ignore A[1:0]; byte LDR zero-extends.
//  Unwritten RAM reads X; the bench stops when IR===X.
//  Reading R15 as an operand yields instruction address+8.
//  Cond[31:28]: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL; 1111 = never.
//  DP, [27:26]=00:
//   I[25], op[24:21], S[20], Rn[19:16], Rd[15:12].
//   I=1: Op2 = imm8 ROR (2*rot4).
//   I=0: Op2 = Rm shifted by shift[6:5], amount imm5[11:7]; register-specified shift unsupported.
//   Opcodes: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN.
//   TST/TEQ/CMP/CMN write no Rd and always set flags.
//  Flags, when S=1 or compare:
//   N=res[31], Z=(res==0).
//   C = carry-out for add; NOT borrow for sub (SUB 3-5 gives C=0); shifter carry for logical ops.
//   V = signed overflow, adds/subs only; V unchanged for logical ops.
//   Arithmetic is 33-bit internally; results truncate to 32 bits (wrap).
//  Writing Rd=R15 loads PC; the next FETCH uses the new PC.
//  LDR/STR, [27:26]=01:
//   I=0 only: 12-bit immediate offset. P, U, B, W, L bits honoured; post-index always writes base.
//   If the load destination equals the base register, the loaded value wins.
//  B/BL, [27:25]=101: PC <= instr_addr+8+(sext(imm24)<<2). BL writes R14 = instr_addr+4.
//  Undefined encodings execute as NOP.
//  run=0 during MEM delays the access; the access completes when run returns to 1.
//  clr asserted mid-instruction aborts it; no partial register/RAM write may complete after reset.
// CONFIGURATION
//  CPU_REG_SHIFT_EN
//   Defined: I=0 operands apply the immediate shift (LSL/LSR/ASR/ROR, amount 0 per ARM rules).
//   Undefined: Op2=Rm unshifted and shifter carry = C.
// STRUCTURE
//  Package cpu_pkg:
//   state enum (FETCH/EXEC/MEM)
//   DP opcode constants
//   condition-code constants
//   cond_pass() function
//  Sub-modules:
//   alu: a, b, cin, op -> res, nzcv; instantiated once.
//   ram: instance name "ram", byte array Mem[0:MEM_BYTES-1].
//   Register file and FSM are inline.
// TESTING
//  MOV R1,#4 (E3A01004) then ADD R1,R1,#8 (E2811008) -> R1=12, flags unchanged, PC=8.
//  MOV R2,#3; SUBS R2,R2,#5 -> R2=FFFFFFFE, N=1 Z=0 C=0 V=0.
//   Also 7FFFFFFF+1 via ADDS -> V=1, N=1.
//  CMP R0,R0 then ADDNE R3,R3,#1 -> R3 unchanged.
//   Same program with ADDEQ -> R3=1; a cond=1111 instruction never executes.
//  STR R1,[R0,#16], then LDRB R4,[R0,#19] -> Mem[16..19]=0000000C, R4=0C.
//  LDR R5,[R0,#16] -> R5=0000000C.
//  BL +8 -> R14=ret address, PC target correct; B -2 loop keeps PC constant.
//   Pulse clr low mid-loop -> PC=0, all registers 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the ARM-subset CPU: FSM states, DP opcodes,
// condition codes and the condition evaluator.
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      MEM   = 2'd2
   } state_e;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // flags are packed {N,Z,C,V}
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         COND_EQ: cond_pass = z;
         COND_NE: cond_pass = !z;
         COND_CS: cond_pass = c;
         COND_CC: cond_pass = !c;
         COND_MI: cond_pass = n;
         COND_PL: cond_pass = !n;
         COND_VS: cond_pass = v;
         COND_VC: cond_pass = !v;
         COND_HI: cond_pass = c && !z;
         COND_LS: cond_pass = !c || z;
         COND_GE: cond_pass = (n == v);
         COND_LT: cond_pass = (n != v);
         COND_GT: cond_pass = !z && (n == v);
         COND_LE: cond_pass = z || (n != v);
         COND_AL: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Data-processing ALU: 33-bit add/sub path plus logical ops, producing NZCV.
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   input  logic        shc_i,
   input  logic        vin_i,
   input  logic [3:0]  op_i,
   output logic [31:0] res_o,
   output logic [3:0]  nzcv_o
);

   logic [31:0] x, y, lres;
   logic        ci, arith;
   logic [32:0] sum;

   // subtracts are folded into x + ~y + ci so C is NOT borrow
   always_comb begin
      x     = a_i;
      y     = b_i;
      ci    = 1'b0;
      arith = 1'b1;
      case (op_i)
         OP_SUB, OP_CMP: begin y = ~b_i; ci = 1'b1; end
         OP_RSB:         begin x = b_i; y = ~a_i; ci = 1'b1; end
         OP_ADD, OP_CMN: begin end
         OP_ADC:         ci = cin_i;
         OP_SBC:         begin y = ~b_i; ci = cin_i; end
         OP_RSC:         begin x = b_i; y = ~a_i; ci = cin_i; end
         default:        arith = 1'b0;
      endcase
   end

   always_comb begin
      lres = '0;
      case (op_i)
         OP_AND, OP_TST: lres = a_i & b_i;
         OP_EOR, OP_TEQ: lres = a_i ^ b_i;
         OP_ORR:         lres = a_i | b_i;
         OP_MOV:         lres = b_i;
         OP_BIC:         lres = a_i & ~b_i;
         OP_MVN:         lres = ~b_i;
         default:        lres = '0;
      endcase
   end

   assign sum    = {1'b0, x} + {1'b0, y} + {32'd0, ci};
   assign res_o  = arith ? sum[31:0] : lres;
   assign nzcv_o = {res_o[31],
                    res_o == 32'd0,
                    arith ? sum[32] : shc_i,
                    arith ? ((x[31] == y[31]) && (sum[31] != x[31])) : vin_i};

endmodule

// File: rtl/cpu_ram.sv
// Byte-wide RAM, big-endian word view, async read, addresses wrap modulo MEM_BYTES.
module cpu_ram #(
   parameter int MEM_BYTES = 256
) (
   input  logic        clk,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic        byte_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rword_o,
   output logic [7:0]  rbyte_o
);

   localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

   logic [7:0] Mem [0:MEM_BYTES-1];

   function automatic logic [AW-1:0] wrap(input logic [31:0] a);
      return AW'(a % 32'(MEM_BYTES));
   endfunction

   logic [31:0]   wa;
   logic [AW-1:0] ib, iw0, iw1, iw2, iw3;

   assign wa  = {addr_i[31:2], 2'b00};
   assign ib  = wrap(addr_i);
   assign iw0 = wrap(wa);
   assign iw1 = wrap(wa + 32'd1);
   assign iw2 = wrap(wa + 32'd2);
   assign iw3 = wrap(wa + 32'd3);

   assign rword_o = {Mem[iw0], Mem[iw1], Mem[iw2], Mem[iw3]};
   assign rbyte_o = Mem[ib];

   always_ff @(posedge clk) begin
      if (we_i) begin
         if (byte_i) begin
            Mem[ib] <= wdata_i[7:0];
         end else begin
            Mem[iw0] <= wdata_i[31:24];
            Mem[iw1] <= wdata_i[23:16];
            Mem[iw2] <= wdata_i[15:8];
            Mem[iw3] <= wdata_i[7:0];
         end
      end
   end

endmodule

// File: rtl/cpu.sv
// Multi-cycle ARM-subset CPU (FETCH/EXEC/MEM) with internal RAM.
// Build option CPU_REG_SHIFT_EN enables the immediate shifter on register operands.
module cpu
   import cpu_pkg::*;
#(
   parameter int          MEM_BYTES = 256,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input logic clk,
   input logic clr,
   input logic run,
   input logic halt
);

   state_e      state_q, state_d;
   logic [31:0] rf_q [0:14];
   logic [31:0] pc_q, pc_d;
   logic [31:0] IR, ir_d;
   logic [3:0]  nzcv_q, nzcv_d;
   logic [31:0] addr_q, addr_d, wbv_q, wbv_d;

   logic        w0_en, w1_en;
   logic [3:0]  w0_idx, w1_idx;
   logic [31:0] w0_val, w1_val;

   logic [31:0] rn_val, rd_val, rm_val, op2, alu_res;
   logic [3:0]  alu_nzcv;
   logic        shc, cond_ok, is_dp, is_mem, is_br, is_cmp;
   logic [31:0] off, off_addr, ea, br_tgt, ld_val;
   logic [31:0] ram_addr, ram_word;
   logic [7:0]  ram_byte;
   logic        mem_we;

   // pc_q already points at instr+4, so R15 reads as instr+8
   assign rn_val = (IR[19:16] == 4'd15) ? pc_q + 32'd4 : rf_q[IR[19:16]];
   assign rd_val = (IR[15:12] == 4'd15) ? pc_q + 32'd4 : rf_q[IR[15:12]];
   assign rm_val = (IR[3:0]   == 4'd15) ? pc_q + 32'd4 : rf_q[IR[3:0]];

   assign cond_ok = cond_pass(IR[31:28], nzcv_q);
   assign is_dp   = (IR[27:26] == 2'b00) && (IR[25] || !IR[4]);
   assign is_mem  = (IR[27:25] == 3'b010);
   assign is_br   = (IR[27:25] == 3'b101);
   assign is_cmp  = (IR[24:23] == 2'b10);

   logic [31:0] imm_r;
   assign imm_r = ({24'd0, IR[7:0]} >> {IR[11:8], 1'b0}) |
                  ({24'd0, IR[7:0]} << (6'd32 - {1'b0, IR[11:8], 1'b0}));

`ifdef CPU_REG_SHIFT_EN
   logic [32:0] sh_t;
   logic [4:0]  amt;
   assign amt = IR[11:7];

   always_comb begin
      op2  = rm_val;
      shc  = nzcv_q[1];
      sh_t = '0;
      if (IR[25]) begin
         op2 = imm_r;
         shc = (IR[11:8] == 4'd0) ? nzcv_q[1] : imm_r[31];
      end else begin
         // amount 0 encodes LSL#0, LSR#32, ASR#32 and RRX
         case (IR[6:5])
            2'b00: begin
               sh_t = {1'b0, rm_val} << amt;
               if (amt != 5'd0) begin op2 = sh_t[31:0]; shc = sh_t[32]; end
            end
            2'b01: begin
               sh_t = {rm_val, 1'b0} >> amt;
               if (amt == 5'd0) begin op2 = '0; shc = rm_val[31]; end
               else begin op2 = sh_t[32:1]; shc = sh_t[0]; end
            end
            2'b10: begin
               sh_t = $signed({rm_val, 1'b0}) >>> amt;
               if (amt == 5'd0) begin op2 = {32{rm_val[31]}}; shc = rm_val[31]; end
               else begin op2 = sh_t[32:1]; shc = sh_t[0]; end
            end
            default: begin
               if (amt == 5'd0) begin
                  op2 = {nzcv_q[1], rm_val[31:1]};
                  shc = rm_val[0];
               end else begin
                  op2 = (rm_val >> amt) | (rm_val << (6'd32 - {1'b0, amt}));
                  shc = op2[31];
               end
            end
         endcase
      end
   end
`else
   always_comb begin
      op2 = rm_val;
      shc = nzcv_q[1];
      if (IR[25]) begin
         op2 = imm_r;
         shc = (IR[11:8] == 4'd0) ? nzcv_q[1] : imm_r[31];
      end
   end
`endif

   cpu_alu alu (
      .a_i    (rn_val),
      .b_i    (op2),
      .cin_i  (nzcv_q[1]),
      .shc_i  (shc),
      .vin_i  (nzcv_q[0]),
      .op_i   (IR[24:21]),
      .res_o  (alu_res),
      .nzcv_o (alu_nzcv)
   );

   assign off      = {20'd0, IR[11:0]};
   assign off_addr = IR[23] ? rn_val + off : rn_val - off;
   assign ea       = IR[24] ? off_addr : rn_val;
   assign br_tgt   = pc_q + 32'd4 + {{6{IR[23]}}, IR[23:0], 2'b00};

   assign ram_addr = (state_q == MEM) ? addr_q : pc_q;
   assign ld_val   = IR[22] ? {24'd0, ram_byte} : ram_word;
   assign mem_we   = clr && run && (state_q == MEM) && !IR[20];

   cpu_ram #(.MEM_BYTES(MEM_BYTES)) ram (
      .clk     (clk),
      .addr_i  (ram_addr),
      .we_i    (mem_we),
      .byte_i  (IR[22]),
      .wdata_i (rd_val),
      .rword_o (ram_word),
      .rbyte_o (ram_byte)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = IR;
      nzcv_d  = nzcv_q;
      addr_d  = addr_q;
      wbv_d   = wbv_q;
      w0_en   = 1'b0;
      w0_idx  = 4'd0;
      w0_val  = '0;
      w1_en   = 1'b0;
      w1_idx  = 4'd0;
      w1_val  = '0;
      case (state_q)
         FETCH: begin
            if (!halt) begin
               ir_d    = ram_word;
               pc_d    = pc_q + 32'd4;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = FETCH;
            if (cond_ok) begin
               if (is_dp) begin
                  w0_en  = !is_cmp;
                  w0_idx = IR[15:12];
                  w0_val = alu_res;
                  if (IR[20] || is_cmp) nzcv_d = alu_nzcv;
               end else if (is_br) begin
                  pc_d   = br_tgt;
                  w0_en  = IR[24];
                  w0_idx = 4'd14;
                  w0_val = pc_q;
               end else if (is_mem) begin
                  addr_d  = ea;
                  wbv_d   = off_addr;
                  state_d = MEM;
               end
            end
         end
         MEM: begin
            state_d = FETCH;
            w0_en   = IR[21] || !IR[24];
            w0_idx  = IR[19:16];
            w0_val  = wbv_q;
            // load uses the later port so it wins over base writeback
            w1_en   = IR[20];
            w1_idx  = IR[15:12];
            w1_val  = ld_val;
         end
         default: state_d = FETCH;
      endcase
      if (w0_en && w0_idx == 4'd15) pc_d = w0_val;
      if (w1_en && w1_idx == 4'd15) pc_d = w1_val;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         IR      <= '0;
         nzcv_q  <= '0;
         addr_q  <= '0;
         wbv_q   <= '0;
         for (int i = 0; i < 15; i++) rf_q[i] <= '0;
      end else if (run) begin
         state_q <= state_d;
         pc_q    <= pc_d;
         IR      <= ir_d;
         nzcv_q  <= nzcv_d;
         addr_q  <= addr_d;
         wbv_q   <= wbv_d;
         for (int i = 0; i < 15; i++) begin
            if (w0_en && w0_idx == 4'(i)) rf_q[i] <= w0_val;
            if (w1_en && w1_idx == 4'(i)) rf_q[i] <= w1_val;
         end
      end
   end

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: directed programs preloaded into RAM, expectations
// queued by the stimulus and checked by a monitor when the core is halted or frozen.
module tb_cpu;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic clr = 1'b0;
   logic run = 1'b1;
   logic halt = 1'b1;

   cpu dut (.clk(clk), .clr(clr), .run(run), .halt(halt));

   always #5 clk = ~clk;

   typedef enum int {K_REG, K_NZCV, K_MEM, K_IR, K_STATE} kind_e;
   typedef struct {
      string       name;
      kind_e       kind;
      int          idx;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [31:0] LOOP = 32'hEAFFFFFE;

   function automatic logic [31:0] actual(kind_e k, int idx);
      case (k)
         K_REG:   return (idx == 15) ? dut.pc_q : dut.rf_q[idx];
         K_NZCV:  return {28'd0, dut.nzcv_q};
         K_MEM:   return {dut.ram.Mem[idx], dut.ram.Mem[idx+1], dut.ram.Mem[idx+2], dut.ram.Mem[idx+3]};
         K_IR:    return dut.IR;
         default: return 32'(dut.state_q);
      endcase
   endfunction

   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [31:0] a;
      if (sb.size() > 0 && ((halt && dut.state_q == FETCH) || !run)) begin
         while (sb.size() > 0) begin
            e = sb.pop_front();
            a = actual(e.kind, e.idx);
            checks++;
            if (a !== e.exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
            end
         end
      end
   end

   task automatic expect_v(input string n, input kind_e k, input int idx, input logic [31:0] v);
      exp_t e;
      e.name = n; e.kind = k; e.idx = idx; e.exp = v;
      sb.push_back(e);
   endtask

   task automatic drain(input string n);
      int t = 0;
      while (sb.size() > 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s_drain: %0d pending expectations, required 0", n, sb.size());
         sb.delete();
      end
   endtask

   task automatic put(input int a, input logic [31:0] w);
      dut.ram.Mem[a]   = w[31:24];
      dut.ram.Mem[a+1] = w[23:16];
      dut.ram.Mem[a+2] = w[15:8];
      dut.ram.Mem[a+3] = w[7:0];
   endtask

   task automatic start();
      halt = 1'b1;
      run  = 1'b1;
      clr  = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 256; i++) dut.ram.Mem[i] = 8'h00;
   endtask

   task automatic go();
      @(negedge clk);
      clr  = 1'b1;
      halt = 1'b0;
   endtask

   task automatic wait_ir(input string n, input logic [31:0] w);
      int t = 0;
      while (dut.IR !== w && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (dut.IR !== w) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: IR %h, required %h", n, dut.IR, w);
      end
   endtask

   task automatic wait_mem(input string n);
      int t = 0;
      while (dut.state_q != MEM && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (dut.state_q != MEM) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: state %0d, required %0d", n, dut.state_q, MEM);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      start();
      for (int i = 0; i < 15; i++) expect_v($sformatf("rst_r%0d", i), K_REG, i, 32'd0);
      expect_v("rst_pc", K_REG, 15, 32'd0);
      expect_v("rst_nzcv", K_NZCV, 0, 32'd0);
      expect_v("rst_ir", K_IR, 0, 32'd0);
      expect_v("rst_state", K_STATE, 0, 32'(FETCH));
      drain("rst");

      // MOV / ADD, flags untouched
      start();
      put(0, 32'hE3A01004); put(4, 32'hE2811008); put(8, LOOP);
      go(); wait_ir("t1", LOOP);
      expect_v("t1_r1", K_REG, 1, 32'd12);
      expect_v("t1_nzcv", K_NZCV, 0, 32'h0);
      expect_v("t1_pc", K_REG, 15, 32'd8);
      halt = 1'b1; drain("t1");

      // SUBS 3-5
      start();
      put(0, 32'hE3A02003); put(4, 32'hE2522005); put(8, LOOP);
      go(); wait_ir("t2", LOOP);
      expect_v("t2_r2", K_REG, 2, 32'hFFFFFFFE);
      expect_v("t2_nzcv", K_NZCV, 0, 32'h8);
      halt = 1'b1; drain("t2");

      // 7FFFFFFF + 1 overflow
      start();
      put(0, 32'hE3E03102); put(4, 32'hE2934001); put(8, LOOP);
      go(); wait_ir("t3", LOOP);
      expect_v("t3_r3", K_REG, 3, 32'h7FFFFFFF);
      expect_v("t3_r4", K_REG, 4, 32'h80000000);
      expect_v("t3_nzcv", K_NZCV, 0, 32'h9);
      halt = 1'b1; drain("t3");

      // conditions: CMP R0,R0; ADDNE R3; ADDEQ R5; never-cond ADD R6
      start();
      put(0, 32'hE1500000); put(4, 32'h12833001); put(8, 32'h02855001);
      put(12, 32'hF2866001); put(16, LOOP);
      go(); wait_ir("t4", LOOP);
      expect_v("t4_r3_ne", K_REG, 3, 32'd0);
      expect_v("t4_r5_eq", K_REG, 5, 32'd1);
      expect_v("t4_r6_nv", K_REG, 6, 32'd0);
      expect_v("t4_nzcv", K_NZCV, 0, 32'h6);
      expect_v("t4_pc", K_REG, 15, 32'd16);
      halt = 1'b1; drain("t4");

      // STR / LDRB / LDR
      start();
      put(0, 32'hE3A0100C); put(4, 32'hE5801040); put(8, 32'hE5D04043);
      put(12, 32'hE5905040); put(16, LOOP);
      go(); wait_ir("t5", LOOP);
      expect_v("t5_mem40", K_MEM, 'h40, 32'h0000000C);
      expect_v("t5_r4_ldrb", K_REG, 4, 32'h0000000C);
      expect_v("t5_r5_ldr", K_REG, 5, 32'h0000000C);
      halt = 1'b1; drain("t5");

      // post-index STRB, pre-index writeback load into base, wrap, unaligned word
      start();
      put(0, 32'hE3A010AB); put(4, 32'hE3A02080); put(8, 32'hE4C21004);
      put(12, 32'hE5322004); put(16, 32'hE5D03180); put(20, 32'hE5904082);
      put(24, LOOP);
      go(); wait_ir("t6", LOOP);
      expect_v("t6_mem80", K_MEM, 'h80, 32'hAB000000);
      expect_v("t6_r2_ldwins", K_REG, 2, 32'hAB000000);
      expect_v("t6_r3_wrap", K_REG, 3, 32'h000000AB);
      expect_v("t6_r4_align", K_REG, 4, 32'hAB000000);
      expect_v("t6_pc", K_REG, 15, 32'd24);
      halt = 1'b1; drain("t6");

      // BL, PC as operand, MOV PC
      start();
      put(0, 32'hEB000002); put(4, 32'hE3A07001); put(8, 32'hE3A07001);
      put(12, 32'hE3A07001); put(16, 32'hE3A08002); put(20, 32'hE28F9000);
      put(24, 32'hE3A0F030); put(28, 32'hE3A07001); put(32'h2C, 32'hE3A07001);
      put(32'h30, LOOP);
      go(); wait_ir("t7", LOOP);
      expect_v("t7_r14_link", K_REG, 14, 32'd4);
      expect_v("t7_r7_skipped", K_REG, 7, 32'd0);
      expect_v("t7_r8", K_REG, 8, 32'd2);
      expect_v("t7_r9_pcread", K_REG, 9, 32'h1C);
      expect_v("t7_pc", K_REG, 15, 32'h30);
      halt = 1'b1; drain("t7");

      // register operand: ADD R2,R1,R1,LSL#2 and MOVS R3,R1,LSR#1
      start();
      put(0, 32'hE3A01003); put(4, 32'hE0812101); put(8, 32'hE1B030A1); put(12, LOOP);
      go(); wait_ir("t8", LOOP);
`ifdef CPU_REG_SHIFT_EN
      expect_v("t8_r2", K_REG, 2, 32'd15);
      expect_v("t8_r3", K_REG, 3, 32'd1);
      expect_v("t8_nzcv", K_NZCV, 0, 32'h2);
`else
      expect_v("t8_r2", K_REG, 2, 32'd6);
      expect_v("t8_r3", K_REG, 3, 32'd3);
      expect_v("t8_nzcv", K_NZCV, 0, 32'h0);
`endif
      halt = 1'b1; drain("t8");

      // run=0 during MEM holds the store
      start();
      put(0, 32'hE3A0105A); put(4, 32'hE5801040); put(8, LOOP);
      go(); wait_mem("t9");
      run = 1'b0;
      expect_v("t9_frz_mem40", K_MEM, 'h40, 32'h0);
      expect_v("t9_frz_state", K_STATE, 0, 32'(MEM));
      expect_v("t9_frz_pc", K_REG, 15, 32'd8);
      drain("t9a");
      repeat (4) @(negedge clk);
      expect_v("t9_hold_state", K_STATE, 0, 32'(MEM));
      expect_v("t9_hold_mem40", K_MEM, 'h40, 32'h0);
      drain("t9b");
      run = 1'b1;
      wait_ir("t9", LOOP);
      expect_v("t9_mem40", K_MEM, 'h40, 32'h0000005A);
      halt = 1'b1; drain("t9c");

      // reset during MEM aborts the store; reset mid-loop clears the core
      start();
      put(0, 32'hE3A01004); put(4, 32'hE5801040); put(8, LOOP);
      go(); wait_mem("t10");
      halt = 1'b1;
      clr  = 1'b0;
      expect_v("t10_abort_mem40", K_MEM, 'h40, 32'h0);
      expect_v("t10_abort_r1", K_REG, 1, 32'h0);
      expect_v("t10_abort_pc", K_REG, 15, 32'h0);
      expect_v("t10_abort_ir", K_IR, 0, 32'h0);
      drain("t10a");
      go(); wait_ir("t10", LOOP);
      repeat (6) @(negedge clk);
      halt = 1'b1;
      clr  = 1'b0;
      expect_v("t10_loop_pc", K_REG, 15, 32'h0);
      expect_v("t10_loop_r1", K_REG, 1, 32'h0);
      expect_v("t10_loop_nzcv", K_NZCV, 0, 32'h0);
      expect_v("t10_loop_state", K_STATE, 0, 32'(FETCH));
      expect_v("t10_loop_mem40", K_MEM, 'h40, 32'h00000004);
      drain("t10b");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
